serial_loader: RTL and testbench

SERIAL_LOADER -- requirements
Module: serial_loader

---
 rtl/serial_loader_if.sv | 12 +
 rtl/serial_loader.sv | 257 +++++++++++++++++++++++++
 tb/tb_serial_loader.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_loader_if.sv
// Write-only RAM bus between the serial loader (master) and a RAM slave.
// The master holds valid with address/wdata/wstrobe steady until it samples ready high.
interface serial_loader_if;
  logic        valid;
  logic        ready;
  logic [31:0] address;
  logic [3:0]  wstrobe;
  logic [31:0] wdata;

  modport master (output valid, address, wstrobe, wdata, input ready);
  modport slave  (input valid, address, wstrobe, wdata, output ready);
endinterface

// File: rtl/serial_loader.sv
// UART boot loader. It receives a frame of the form
//   HEADER, address (4 bytes LE), word count N (2 bytes LE), N words (4 bytes LE each),
// writes each word to RAM over the bus, and then releases the CPU from reset.
// Optional feature macro SERIAL_LOADER_CHECKSUM_EN: the frame carries one trailing
// byte that must equal the mod-256 sum of all data bytes.
module serial_loader #(
  parameter int         DIVISOR = 868,
  parameter logic [7:0] HEADER  = 8'hA5
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           rx,
  serial_loader_if.master bus,
  output logic           cpu_hold,
  output logic           done,
  output logic           error
);

  localparam int CNT_W = $clog2(DIVISOR);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(DIVISOR / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(DIVISOR - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {
    ST_HEADER, ST_ADDR, ST_COUNT, ST_DATA, ST_WRITE, ST_CHECK, ST_DONE, ST_ERROR
  } ld_state_t;

  logic             rx_s1, rx_s2, rx_prev;
  rx_state_t        rx_state;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       rx_shift;
  logic             byte_stb;
  logic             frame_err;

  ld_state_t        ld_state;
  logic [1:0]       byte_idx;
  logic [15:0]      word_cnt;
  logic [31:0]      word_sh;
  logic             fault_pend;
  logic             buf_full;
  logic [7:0]       buf_data;

  logic             in_vld;
  logic [7:0]       in_byte;
  logic             consuming;
  logic             overrun;
  logic [31:0]      word_next;
  logic [15:0]      cnt_next;

  // A buffered byte always goes ahead of a freshly received one.
  assign in_vld    = buf_full | byte_stb;
  assign in_byte   = buf_full ? buf_data : rx_shift;
  assign consuming = ld_state inside {ST_HEADER, ST_ADDR, ST_COUNT, ST_DATA, ST_CHECK};
  assign overrun   = (ld_state == ST_WRITE) && byte_stb && buf_full;
  assign word_next = {in_byte, word_sh[31:8]};
  assign cnt_next  = {in_byte, word_cnt[15:8]};

  // Two-flop synchronizer plus one delayed copy for falling-edge detection; idle line is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // UART receiver: mid-bit sampling, LSB first, strobe or framing fault after the stop bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state  <= RX_IDLE;
      bit_cnt   <= '0;
      bit_idx   <= 3'd0;
      rx_shift  <= 8'd0;
      byte_stb  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      byte_stb  <= 1'b0;
      frame_err <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s2) begin
            bit_cnt  <= HALF_BIT;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (bit_cnt != '0) begin
            bit_cnt <= bit_cnt - 1'b1;
          end else if (rx_s2) begin
            rx_state <= RX_IDLE;            // glitch, not a real start bit
          end else begin
            bit_cnt  <= FULL_BIT;
            bit_idx  <= 3'd0;
            rx_state <= RX_DATA;
          end
        end
        RX_DATA: begin
          if (bit_cnt != '0) begin
            bit_cnt <= bit_cnt - 1'b1;
          end else begin
            rx_shift <= {rx_s2, rx_shift[7:1]};
            bit_cnt  <= FULL_BIT;
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
            else                 bit_idx  <= bit_idx + 3'd1;
          end
        end
        RX_STOP: begin
          if (bit_cnt != '0) begin
            bit_cnt <= bit_cnt - 1'b1;
          end else begin
            rx_state <= RX_IDLE;
            if (rx_s2) byte_stb  <= 1'b1;
            else       frame_err <= 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // One-byte holding buffer: fills while a write is stalled, drains as soon as bytes are consumed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_full <= 1'b0;
      buf_data <= 8'd0;
    end else if (ld_state == ST_WRITE) begin
      if (byte_stb && !buf_full) begin
        buf_full <= 1'b1;
        buf_data <= rx_shift;
      end
    end else if (consuming) begin
      // Buffered byte is consumed this cycle; a coinciding new byte takes its place.
      buf_full <= buf_full & byte_stb;
      if (byte_stb) buf_data <= rx_shift;
    end else begin
      buf_full <= 1'b0;
    end
  end

`ifdef SERIAL_LOADER_CHECKSUM_EN
  logic [7:0] csum;

  // Running mod-256 sum of every data byte accepted into a word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                             csum <= 8'd0;
    else if (ld_state == ST_DATA && in_vld && !frame_err)   csum <= csum + in_byte;
  end
`endif

  // Loader FSM: parses the frame and drives the bus and status outputs from registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_state    <= ST_HEADER;
      byte_idx    <= 2'd0;
      word_cnt    <= 16'd0;
      word_sh     <= 32'd0;
      fault_pend  <= 1'b0;
      bus.valid   <= 1'b0;
      bus.address <= 32'd0;
      bus.wstrobe <= 4'h0;
      bus.wdata   <= 32'd0;
      cpu_hold    <= 1'b1;
      done        <= 1'b0;
      error       <= 1'b0;
    end else if (frame_err && consuming) begin
      ld_state <= ST_ERROR;
      error    <= 1'b1;
    end else begin
      case (ld_state)
        ST_HEADER: begin
          if (in_vld && in_byte == HEADER) begin
            byte_idx <= 2'd0;
            ld_state <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (in_vld) begin
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              bus.address <= {in_byte, bus.address[31:10], 2'b00};
              ld_state    <= ST_COUNT;
            end else begin
              bus.address <= {in_byte, bus.address[31:8]};
            end
          end
        end
        ST_COUNT: begin
          if (in_vld) begin
            word_cnt <= cnt_next;
            if (byte_idx[0]) begin
              byte_idx <= 2'd0;
              ld_state <= (cnt_next == 16'd0) ? ST_CHECK : ST_DATA;
            end else begin
              byte_idx <= 2'd1;
            end
          end
        end
        ST_DATA: begin
          if (in_vld) begin
            word_sh  <= word_next;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              bus.valid   <= 1'b1;
              bus.wstrobe <= 4'hF;
              bus.wdata   <= word_next;
              ld_state    <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          // Faults seen mid-write are remembered and acted on once the handshake completes.
          if (frame_err || overrun) fault_pend <= 1'b1;
          if (bus.ready) begin
            bus.valid   <= 1'b0;
            bus.wstrobe <= 4'h0;
            bus.wdata   <= 32'd0;
            bus.address <= bus.address + 32'd4;
            word_cnt    <= word_cnt - 16'd1;
            if (fault_pend || frame_err || overrun) begin
              ld_state <= ST_ERROR;
              error    <= 1'b1;
            end else if (word_cnt == 16'd1) begin
              ld_state <= ST_CHECK;
            end else begin
              ld_state <= ST_DATA;
            end
          end
        end
        ST_CHECK: begin
`ifdef SERIAL_LOADER_CHECKSUM_EN
          if (in_vld) begin
            if (in_byte == csum) begin
              ld_state <= ST_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              ld_state <= ST_ERROR;
              error    <= 1'b1;
            end
          end
`else
          ld_state <= ST_DONE;
          done     <= 1'b1;
          cpu_hold <= 1'b0;
`endif
        end
        default: ;                          // DONE and ERROR hold until reset
      endcase
    end
  end

endmodule

// File: tb/tb_serial_loader.sv
// Directed bench for serial_loader with a scoreboard of expected bus writes.
module tb_serial_loader;
  localparam int DIV = 4;

  logic clk = 1'b0;
  logic reset;
  logic rx;
  logic cpu_hold, done, error;

  serial_loader_if bus();

  serial_loader #(.DIVISOR(DIV), .HEADER(8'hA5)) dut (
    .clk(clk), .reset(reset), .rx(rx), .bus(bus),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
  wr_t        sb[$];
  logic [7:0] frame[$];
  int         bad_idx   = -1;
  int         rdy_delay = 0;
  int         writes    = 0;
  int         idle_viol = 0;
  bit         valid_seen = 1'b0;
  int         tests = 0;
  int         fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx = stop;
    repeat (DIV) @(negedge clk);
    if (!stop) begin
      rx = 1'b1;
      repeat (2 * DIV) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic send_frame();
    foreach (frame[i]) send_byte(frame[i], (i != bad_idx));
    rx = 1'b1;
    frame.delete();
    bad_idx = -1;
  endtask

  // Builds a frame and pushes the first n_exp writes it should produce.
  task automatic make_frame(input logic [31:0] addr, input int n, input logic [31:0] w0,
                            input logic [31:0] w1, input int n_exp);
    logic [31:0] wa;
    logic [31:0] ww;
    logic [15:0] n16;
`ifdef SERIAL_LOADER_CHECKSUM_EN
    logic [7:0]  cs;
    cs = 8'd0;
`endif
    n16 = 16'(n);
    wa  = {addr[31:2], 2'b00};
    frame.delete();
    frame.push_back(8'hA5);
    for (int i = 0; i < 4; i++) frame.push_back(addr[8*i +: 8]);
    frame.push_back(n16[7:0]);
    frame.push_back(n16[15:8]);
    for (int k = 0; k < n; k++) begin
      ww = (k == 0) ? w0 : w1;
      for (int i = 0; i < 4; i++) begin
        frame.push_back(ww[8*i +: 8]);
`ifdef SERIAL_LOADER_CHECKSUM_EN
        cs = cs + ww[8*i +: 8];
`endif
      end
      if (k < n_exp) sb.push_back('{a: wa, d: ww});
      wa = wa + 32'd4;
    end
`ifdef SERIAL_LOADER_CHECKSUM_EN
    frame.push_back(cs);
`endif
  endtask

  task automatic wait_status(input string tag, input int budget);
    int c;
    c = 0;
    while (!(done || error) && c < budget) begin
      @(negedge clk);
      c++;
    end
    check1({tag, "_finished"}, done | error, 1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    writes = 0;
    valid_seen = 1'b0;
  endtask

  // RAM slave: waits rdy_delay cycles, checks the write against the scoreboard, pulses ready.
  initial begin
    bus.ready = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.valid === 1'b1) begin
        for (int i = 0; i < rdy_delay && bus.valid === 1'b1; i++) @(negedge clk);
        if (bus.valid === 1'b1) begin
          if (sb.size() == 0) begin
            check("write_expected", 32'(sb.size()), 32'd1);
          end else begin
            wr_t e;
            e = sb.pop_front();
            check("wr_addr", bus.address, e.a);
            check("wr_data", bus.wdata, e.d);
            check("wr_strobe", 32'(bus.wstrobe), 32'hF);
          end
          writes++;
          bus.ready = 1'b1;
          @(negedge clk);
          bus.ready = 1'b0;
        end
      end
    end
  end

  // Bus monitor: records any valid and flags non-zero strobe/data while idle.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.valid === 1'b1) valid_seen = 1'b1;
      else if (reset === 1'b1 && (bus.wstrobe !== 4'h0 || bus.wdata !== 32'h0)) idle_viol++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    rx    = 1'b1;
    repeat (2) @(negedge clk);
    check1("rst_valid", bus.valid, 1'b0);
    check("rst_address", bus.address, 32'h0);
    check("rst_wstrobe", 32'(bus.wstrobe), 32'h0);
    check("rst_wdata", bus.wdata, 32'h0);
    check1("rst_cpu_hold", cpu_hold, 1'b1);
    check1("rst_done", done, 1'b0);
    check1("rst_error", error, 1'b0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Basic two-word load at 0x100
    make_frame(32'h00000100, 2, 32'h12345678, 32'hDEADBEEF, 2);
    send_frame();
    wait_status("a", 2000);
    check1("a_done", done, 1'b1);
    check1("a_cpu_hold", cpu_hold, 1'b0);
    check1("a_error", error, 1'b0);
    check("a_writes", 32'(writes), 32'd2);
    check("a_sb_empty", 32'(sb.size()), 32'd0);

    // Traffic after DONE is ignored
    make_frame(32'h00000200, 1, 32'h0BADF00D, 32'h0, 0);
    send_frame();
    repeat (20) @(negedge clk);
    check("ign_writes", 32'(writes), 32'd2);
    check1("ign_done", done, 1'b1);
    check1("ign_cpu_hold", cpu_hold, 1'b0);

    // Leading junk bytes, zero word count
    do_reset();
    check1("b_hold_after_reset", cpu_hold, 1'b1);
    make_frame(32'h00000000, 0, 32'h0, 32'h0, 0);
    frame.push_front(8'hFF);
    frame.push_front(8'h00);
    send_frame();
    wait_status("b", 2000);
    check1("b_done", done, 1'b1);
    check1("b_error", error, 1'b0);
    check("b_writes", 32'(writes), 32'd0);

    // Framing fault on the third byte
    do_reset();
    make_frame(32'h00000100, 1, 32'h11223344, 32'h0, 0);
    frame = frame[0:2];
    bad_idx = 2;
    send_frame();
    wait_status("c", 500);
    check1("c_error", error, 1'b1);
    check1("c_cpu_hold", cpu_hold, 1'b1);
    check1("c_done", done, 1'b0);
    check1("c_valid_never", valid_seen, 1'b0);

    // Slow slave: one byte arrives during the stalled write and is buffered
    do_reset();
    rdy_delay = 50;
    make_frame(32'h00000400, 2, 32'hA1B2C3D4, 32'h55AA0FF0, 2);
    send_frame();
    wait_status("d", 2000);
    check1("d_done", done, 1'b1);
    check1("d_error", error, 1'b0);
    check("d_writes", 32'(writes), 32'd2);
    check("d_sb_empty", 32'(sb.size()), 32'd0);

    // Very slow slave: two bytes arrive during one write -> overrun after the handshake
    do_reset();
    rdy_delay = 100;
    make_frame(32'h00000800, 2, 32'h01020304, 32'h05060708, 1);
    send_frame();
    wait_status("e", 2000);
    repeat (5) @(negedge clk);
    check1("e_error", error, 1'b1);
    check1("e_done", done, 1'b0);
    check1("e_cpu_hold", cpu_hold, 1'b1);
    check1("e_valid_low", bus.valid, 1'b0);
    check("e_writes", 32'(writes), 32'd1);
    check("e_sb_empty", 32'(sb.size()), 32'd0);

    // Address wraps from the top of the space to zero
    do_reset();
    rdy_delay = 0;
    make_frame(32'hFFFFFFFC, 2, 32'hCAFEBABE, 32'h13579BDF, 2);
    send_frame();
    wait_status("f", 2000);
    check1("f_done", done, 1'b1);
    check("f_writes", 32'(writes), 32'd2);
    check("f_sb_empty", 32'(sb.size()), 32'd0);

    // Reset while a write is outstanding, then a normal load
    do_reset();
    rdy_delay = 1000;
    make_frame(32'h00000040, 1, 32'h87654321, 32'h0, 1);
    send_frame();
    for (int c = 0; c < 500 && bus.valid !== 1'b1; c++) @(negedge clk);
    check1("g_valid_up", bus.valid, 1'b1);
    reset = 1'b0;
    #1;
    check1("g_valid_drop", bus.valid, 1'b0);
    check1("g_cpu_hold", cpu_hold, 1'b1);
    repeat (2) @(negedge clk);
    sb.delete();
    rdy_delay = 0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    writes = 0;
    make_frame(32'h00000100, 2, 32'h12345678, 32'hDEADBEEF, 2);
    send_frame();
    wait_status("g", 2000);
    check1("g_done", done, 1'b1);
    check1("g_error", error, 1'b0);
    check("g_writes", 32'(writes), 32'd2);
    check("g_sb_empty", 32'(sb.size()), 32'd0);

    check("idle_bus_zero", 32'(idle_viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
